// File: rtl/mc_alu.sv
// mc_alu - parametrised multi-cycle ALU with valid/ready handshakes.
//
// Purpose:
//   Executes one opcode per accepted operation. Most opcodes complete in a
//   single cycle. Mul uses an iterative unsigned shift-add multiplier and
//   Div uses an iterative unsigned restoring divider; each runs for WIDTH
//   cycles. Results and flags are registered and held until the consumer
//   takes them.
//
// Ports:
//   clk        in   system clock; all state on the rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand/opcode valid
//   in_ready   out  block can accept an operation this cycle
//   alu_a      in   operand A (WIDTH)
//   alu_b      in   operand B (WIDTH)
//   alu_opc    in   opcode (OPC_W)
//   out_valid  out  result registers hold a valid result
//   out_ready  in   consumer accepts the result
//   alu_out    out  primary result: low product or quotient (WIDTH)
//   alu_out_hi out  high product or remainder, 0 otherwise (WIDTH)
//   flag_z     out  alu_out == 0
//   flag_c     out  carry (ADD/ADI/INC/JMP) or borrow (SUB/DEC)
//   flag_v     out  signed overflow for ADD/ADI/SUB
//   flag_dz    out  Div attempted with alu_b == 0

module mc_alu #(
   parameter int WIDTH = 8,
   parameter int OPC_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] alu_a,
   input  logic [WIDTH-1:0] alu_b,
   input  logic [OPC_W-1:0] alu_opc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_out,
   output logic [WIDTH-1:0] alu_out_hi,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v,
   output logic             flag_dz
);

   // Opcode encodings, in the order of the shared ALU opcode table.
   localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(0);
   localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(1);
   localparam logic [OPC_W-1:0] OP_ADI  = OPC_W'(2);
   localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(3);
   localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(4);
   localparam logic [OPC_W-1:0] OP_DIV  = OPC_W'(5);
   localparam logic [OPC_W-1:0] OP_INC  = OPC_W'(6);
   localparam logic [OPC_W-1:0] OP_DEC  = OPC_W'(7);
   localparam logic [OPC_W-1:0] OP_NOR  = OPC_W'(8);
   localparam logic [OPC_W-1:0] OP_NAND = OPC_W'(9);
   localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'(10);
   localparam logic [OPC_W-1:0] OP_COMP = OPC_W'(11);
   localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(12);
   localparam logic [OPC_W-1:0] OP_CMPJ = OPC_W'(13);

   localparam int               CNT_W    = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH:0]   ONE_X    = {{WIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] work_hi;
   logic [WIDTH-1:0] work_lo;
   logic [WIDTH-1:0] sh_b;

   logic             accept;
   logic [WIDTH-1:0] sc_res;
   logic             sc_c;
   logic             sc_v;
   logic [WIDTH:0]   sc_tmp;
   logic [WIDTH:0]   ext_a;
   logic [WIDTH:0]   ext_b;

   logic [WIDTH-1:0] mul_add;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_trial;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;

   // A finished result can be swapped for a new operation on the same edge
   // the consumer takes it, so back-to-back ops need no bubble.
   assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
   assign accept   = in_valid && in_ready;

   assign ext_a = {1'b0, alu_a};
   assign ext_b = {1'b0, alu_b};

   // Single-cycle result and flags, computed straight from the inputs so
   // they can be registered on the accept edge.
   always_comb begin
      sc_res = alu_a;
      sc_c   = 1'b0;
      sc_v   = 1'b0;
      sc_tmp = '0;
      case (alu_opc)
         OP_ADD, OP_ADI, OP_JMP: begin
            sc_tmp = ext_a + ext_b;
            sc_res = sc_tmp[WIDTH-1:0];
            sc_c   = sc_tmp[WIDTH];
            sc_v   = (alu_opc != OP_JMP) && (alu_a[WIDTH-1] == alu_b[WIDTH-1])
                     && (sc_tmp[WIDTH-1] != alu_a[WIDTH-1]);
         end
         OP_SUB: begin
            sc_tmp = ext_a - ext_b;
            sc_res = sc_tmp[WIDTH-1:0];
            sc_c   = sc_tmp[WIDTH];
            sc_v   = (alu_a[WIDTH-1] != alu_b[WIDTH-1])
                     && (sc_tmp[WIDTH-1] != alu_a[WIDTH-1]);
         end
         OP_INC: begin
            sc_tmp = ext_a + ONE_X;
            sc_res = sc_tmp[WIDTH-1:0];
            sc_c   = sc_tmp[WIDTH];
         end
         OP_DEC: begin
            sc_tmp = ext_a - ONE_X;
            sc_res = sc_tmp[WIDTH-1:0];
            sc_c   = sc_tmp[WIDTH];
         end
         OP_NOR:  sc_res = ~(alu_a | alu_b);
         OP_NAND: sc_res = ~(alu_a & alu_b);
         OP_XOR:  sc_res = alu_a ^ alu_b;
         OP_COMP: sc_res = ~alu_b;
         OP_CMPJ: sc_res = {{(WIDTH-1){1'b0}}, (alu_a >= alu_b)};
         default: sc_res = alu_a;
      endcase
   end

   // One iteration of the multiplier or divider. work_hi/work_lo form a
   // double-width shift register: for Mul it holds {partial product,
   // remaining multiplier bits}, for Div it holds {partial remainder,
   // dividend bits being replaced by quotient bits}.
   always_comb begin
      mul_add   = work_lo[0] ? sh_b : '0;
      mul_sum   = {1'b0, work_hi} + {1'b0, mul_add};
      div_shift = {work_hi, work_lo[WIDTH-1]};
      div_trial = div_shift - {1'b0, sh_b};
      step_hi   = mul_sum[WIDTH:1];
      step_lo   = {mul_sum[0], work_lo[WIDTH-1:1]};
      if (state == ST_DIV) begin
         // A clear top bit of the trial means no borrow: divisor fits.
         if (!div_trial[WIDTH]) begin
            step_hi = div_trial[WIDTH-1:0];
            step_lo = {work_lo[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = div_shift[WIDTH-1:0];
            step_lo = {work_lo[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Control FSM with registered results. Mul/Div iterate with the counter
   // running 0..WIDTH-1; the last iteration writes the result registers
   // directly, so out_valid appears WIDTH+1 cycles after accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         work_hi    <= '0;
         work_lo    <= '0;
         sh_b       <= '0;
         out_valid  <= 1'b0;
         alu_out    <= '0;
         alu_out_hi <= '0;
         flag_z     <= 1'b0;
         flag_c     <= 1'b0;
         flag_v     <= 1'b0;
         flag_dz    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  cnt <= '0;
                  if (alu_opc == OP_MUL) begin
                     state     <= ST_MUL;
                     out_valid <= 1'b0;
                     work_hi   <= '0;
                     work_lo   <= alu_a;
                     sh_b      <= alu_b;
                  end else if ((alu_opc == OP_DIV) && (alu_b != '0)) begin
                     state     <= ST_DIV;
                     out_valid <= 1'b0;
                     work_hi   <= '0;
                     work_lo   <= alu_a;
                     sh_b      <= alu_b;
                  end else if (alu_opc == OP_DIV) begin
                     // Divide by zero skips iteration entirely.
                     state      <= ST_DONE;
                     out_valid  <= 1'b1;
                     alu_out    <= '1;
                     alu_out_hi <= alu_a;
                     flag_z     <= 1'b0;
                     flag_c     <= 1'b0;
                     flag_v     <= 1'b0;
                     flag_dz    <= 1'b1;
                  end else begin
                     state      <= ST_DONE;
                     out_valid  <= 1'b1;
                     alu_out    <= sc_res;
                     alu_out_hi <= '0;
                     flag_z     <= (sc_res == '0);
                     flag_c     <= sc_c;
                     flag_v     <= sc_v;
                     flag_dz    <= 1'b0;
                  end
               end else if ((state == ST_DONE) && out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
               end
            end
            ST_MUL, ST_DIV: begin
               work_hi <= step_hi;
               work_lo <= step_lo;
               cnt     <= cnt + CNT_W'(1);
               if (cnt == CNT_LAST) begin
                  state      <= ST_DONE;
                  out_valid  <= 1'b1;
                  alu_out    <= step_lo;
                  alu_out_hi <= step_hi;
                  flag_z     <= (step_lo == '0);
                  flag_c     <= 1'b0;
                  flag_v     <= 1'b0;
                  flag_dz    <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_alu.sv
// tb_mc_alu - directed self-checking testbench for mc_alu (WIDTH = 8).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_mc_alu;

   localparam int WIDTH = 8;
   localparam int OPC_W = 4;

   localparam logic [3:0] OP_LDI  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_ADI  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_MUL  = 4'd4;
   localparam logic [3:0] OP_DIV  = 4'd5;
   localparam logic [3:0] OP_INC  = 4'd6;
   localparam logic [3:0] OP_DEC  = 4'd7;
   localparam logic [3:0] OP_NOR  = 4'd8;
   localparam logic [3:0] OP_NAND = 4'd9;
   localparam logic [3:0] OP_XOR  = 4'd10;
   localparam logic [3:0] OP_COMP = 4'd11;
   localparam logic [3:0] OP_JMP  = 4'd12;
   localparam logic [3:0] OP_CMPJ = 4'd13;
   localparam logic [3:0] OP_NOP  = 4'd14;
   localparam logic [3:0] OP_HALT = 4'd15;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [OPC_W-1:0] alu_opc;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] alu_out;
   logic [WIDTH-1:0] alu_out_hi;
   logic             flag_z;
   logic             flag_c;
   logic             flag_v;
   logic             flag_dz;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] opc;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       c;
      logic       v;
   } vec_t;

   vec_t vecs[15];

   mc_alu #(.WIDTH(WIDTH), .OPC_W(OPC_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_opc    (alu_opc),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .alu_out    (alu_out),
      .alu_out_hi (alu_out_hi),
      .flag_z     (flag_z),
      .flag_c     (flag_c),
      .flag_v     (flag_v),
      .flag_dz    (flag_dz)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] opc, input logic [7:0] a, input logic [7:0] b);
      in_valid = 1'b1;
      alu_opc  = opc;
      alu_a    = a;
      alu_b    = b;
   endtask

   // Waits for out_valid after an accept edge; lat counts the accept edge as
   // cycle 1, busy counts observed cycles with in_ready low while waiting.
   task automatic waitValid(output int lat, output int busy);
      lat  = 1;
      busy = 0;
      while (!out_valid && lat < 64) begin
         if (!in_ready) busy++;
         step();
         lat++;
      end
   endtask

   task automatic checkResult(input string tag, input logic [7:0] res, input logic [7:0] hi,
                              input logic z, input logic c, input logic v, input logic dz);
      checkOutput({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
      checkOutput({tag, ".out"},   {24'd0, alu_out},   {24'd0, res});
      checkOutput({tag, ".hi"},    {24'd0, alu_out_hi}, {24'd0, hi});
      checkOutput({tag, ".z"},     {31'd0, flag_z},    {31'd0, z});
      checkOutput({tag, ".c"},     {31'd0, flag_c},    {31'd0, c});
      checkOutput({tag, ".v"},     {31'd0, flag_v},    {31'd0, v});
      checkOutput({tag, ".dz"},    {31'd0, flag_dz},   {31'd0, dz});
   endtask

   initial begin
      int lat;
      int busy;
      int seen;

      vecs[0]  = '{OP_LDI,  8'h3C, 8'h11, 8'h3C, 1'b0, 1'b0};
      vecs[1]  = '{OP_ADD,  8'h70, 8'h70, 8'hE0, 1'b0, 1'b1};
      vecs[2]  = '{OP_ADI,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      vecs[3]  = '{OP_SUB,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
      vecs[4]  = '{OP_SUB,  8'h05, 8'h05, 8'h00, 1'b0, 1'b0};
      vecs[5]  = '{OP_INC,  8'h7F, 8'h00, 8'h80, 1'b0, 1'b0};
      vecs[6]  = '{OP_DEC,  8'h00, 8'h00, 8'hFF, 1'b1, 1'b0};
      vecs[7]  = '{OP_NOR,  8'hF0, 8'h0C, 8'h03, 1'b0, 1'b0};
      vecs[8]  = '{OP_NAND, 8'hF0, 8'h3C, 8'hCF, 1'b0, 1'b0};
      vecs[9]  = '{OP_COMP, 8'h12, 8'h55, 8'hAA, 1'b0, 1'b0};
      vecs[10] = '{OP_JMP,  8'h80, 8'h80, 8'h00, 1'b1, 1'b0};
      vecs[11] = '{OP_CMPJ, 8'h03, 8'h09, 8'h00, 1'b0, 1'b0};
      vecs[12] = '{OP_CMPJ, 8'h0A, 8'h09, 8'h01, 1'b0, 1'b0};
      vecs[13] = '{OP_NOP,  8'h42, 8'h00, 8'h42, 1'b0, 1'b0};
      vecs[14] = '{OP_HALT, 8'h99, 8'h01, 8'h99, 1'b0, 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      alu_a     = '0;
      alu_b     = '0;
      alu_opc   = '0;

      // Reset state
      step();
      step();
      checkOutput("rst.valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rst.out",   {24'd0, alu_out},   32'd0);
      checkOutput("rst.hi",    {24'd0, alu_out_hi}, 32'd0);
      checkOutput("rst.flags", {28'd0, flag_z, flag_c, flag_v, flag_dz}, 32'd0);
      checkOutput("rst.ready", {31'd0, in_ready},  32'd1);
      rst_n = 1'b1;
      step();

      // ADD with carry out
      out_ready = 1'b1;
      applyStimulus(OP_ADD, 8'hF0, 8'h20);
      step();
      in_valid = 1'b0;
      waitValid(lat, busy);
      checkOutput("add.lat", lat, 32'd1);
      checkResult("add", 8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      step();
      checkOutput("add.drain", {31'd0, out_valid}, 32'd0);

      // Mul 20 x 20 = 400
      applyStimulus(OP_MUL, 8'd20, 8'd20);
      step();
      in_valid = 1'b0;
      checkOutput("mul1.ready", {31'd0, in_ready}, 32'd0);
      waitValid(lat, busy);
      checkOutput("mul1.lat", lat, 32'd9);
      checkOutput("mul1.busy", busy, 32'd8);
      checkResult("mul1", 8'h90, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);

      // Mul 13 x 11 = 143, issued straight from DONE
      applyStimulus(OP_MUL, 8'd13, 8'd11);
      step();
      in_valid = 1'b0;
      checkOutput("mul2.valid_drop", {31'd0, out_valid}, 32'd0);
      waitValid(lat, busy);
      checkOutput("mul2.lat", lat, 32'd9);
      checkResult("mul2", 8'h8F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Mul 255 x 255 = 0xFE01
      applyStimulus(OP_MUL, 8'hFF, 8'hFF);
      step();
      in_valid = 1'b0;
      waitValid(lat, busy);
      checkResult("mul3", 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);

      // Div 200 / 7 = 28 rem 4
      applyStimulus(OP_DIV, 8'd200, 8'd7);
      step();
      in_valid = 1'b0;
      waitValid(lat, busy);
      checkOutput("div1.lat", lat, 32'd9);
      checkResult("div1", 8'd28, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0);

      // Div 255 / 16 = 15 rem 15
      applyStimulus(OP_DIV, 8'd255, 8'd16);
      step();
      in_valid = 1'b0;
      waitValid(lat, busy);
      checkResult("div2", 8'd15, 8'd15, 1'b0, 1'b0, 1'b0, 1'b0);

      // Div by zero
      applyStimulus(OP_DIV, 8'd5, 8'd0);
      step();
      in_valid = 1'b0;
      waitValid(lat, busy);
      checkOutput("div0.lat", lat, 32'd1);
      checkResult("div0", 8'hFF, 8'd5, 1'b0, 1'b0, 1'b0, 1'b1);
      step();

      // Backpressure: SUB held while out_ready is low, pending ADD ignored
      out_ready = 1'b0;
      applyStimulus(OP_SUB, 8'd3, 8'd5);
      step();
      applyStimulus(OP_ADD, 8'd1, 8'd1);
      checkResult("bp.sub", 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step();
         checkOutput("bp.hold_out",   {24'd0, alu_out},   32'h0000_00FE);
         checkOutput("bp.hold_c",     {31'd0, flag_c},    32'd1);
         checkOutput("bp.hold_valid", {31'd0, out_valid}, 32'd1);
         checkOutput("bp.hold_ready", {31'd0, in_ready},  32'd0);
      end
      out_ready = 1'b1;
      #1;
      checkOutput("bp.release_ready", {31'd0, in_ready}, 32'd1);
      step();
      checkResult("bp.handoff", 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

      // Back-to-back single-cycle ops, no bubbles
      applyStimulus(OP_XOR, 8'h5A, 8'h0F);
      step();
      checkResult("b2b.xor", 8'h55, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(OP_CMPJ, 8'd9, 8'd9);
      step();
      checkResult("b2b.cmpj", 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(OP_INC, 8'hFF, 8'h00);
      step();
      checkResult("b2b.inc", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);

      // Opcode table, also back-to-back
      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].opc, vecs[i].a, vecs[i].b);
         step();
         checkResult($sformatf("tab%0d", i), vecs[i].res, 8'h00,
                     (vecs[i].res == 8'h00), vecs[i].c, vecs[i].v, 1'b0);
      end
      in_valid = 1'b0;
      step();

      // Reset in the middle of a Div
      applyStimulus(OP_DIV, 8'd200, 8'd7);
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      rst_n = 1'b0;
      #1;
      checkOutput("rstmid.valid", {31'd0, out_valid}, 32'd0);
      checkOutput("rstmid.out",   {24'd0, alu_out},   32'd0);
      checkOutput("rstmid.hi",    {24'd0, alu_out_hi}, 32'd0);
      checkOutput("rstmid.flags", {28'd0, flag_z, flag_c, flag_v, flag_dz}, 32'd0);
      checkOutput("rstmid.ready", {31'd0, in_ready},  32'd1);
      step();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (out_valid) seen++;
      end
      checkOutput("rstmid.no_stale", seen, 32'd0);
      checkOutput("rstmid.idle_ready", {31'd0, in_ready}, 32'd1);

      // Normal operation after the aborted op
      applyStimulus(OP_ADD, 8'd1, 8'd2);
      step();
      in_valid = 1'b0;
      waitValid(lat, busy);
      checkOutput("post.lat", lat, 32'd1);
      checkResult("post.add", 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
